// File: rtl/vid_bus_pkg.sv
// Shared request/response bus definitions used by the video fetch initiator
// and the memory target.
package vid_bus_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE   = 3'b000,
    CMD_READ   = 3'b001,
    CMD_WRITE  = 3'b010,
    CMD_WRDATA = 3'b011,
    CMD_RDDATA = 3'b100,
    CMD_ERR    = 3'b111
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RWAIT = 3'd1,
    ST_RDATA = 3'd2,
    ST_WDATA = 3'd3,
    ST_ERR   = 3'd4
  } tgt_state_t;

  typedef struct packed {
    logic        sel;
    cmd_t        cmd;
    logic [1:0]  len;
    logic [31:0] data;
  } rsp_t;

  localparam logic [3:0] TID_MEM = 4'h1;
  localparam logic [3:0] TID_AUX = 4'h2;

  localparam rsp_t RSP_IDLE = '{sel: 1'b0, cmd: CMD_IDLE, len: 2'b00, data: 32'h0000_0000};

  function automatic logic [3:0] len_to_beats(input logic [1:0] len);
    case (len)
      2'd0:    len_to_beats = 4'd1;
      2'd1:    len_to_beats = 4'd2;
      2'd2:    len_to_beats = 4'd4;
      2'd3:    len_to_beats = 4'd8;
      default: len_to_beats = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/vid_mem_sp_ram.sv
// Single-port synchronous RAM, one write or one read per cycle, registered
// read data. Contents are deliberately not reset.
module vid_mem_sp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write takes the port; otherwise the addressed word is read into rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/vid_mem_target.sv
// Bus target holding a word-addressed frame/line store; accepts read/write
// bursts from the video fetch initiator and returns read beats.
module vid_mem_target
  import vid_bus_pkg::*;
#(
  parameter logic [3:0] TARGET_ID  = TID_MEM,
  parameter int         DEPTH      = 1024,
  parameter int         RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  reqin,
  input  logic [3:0]  reqtar,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  output logic        ackout,
  output logic        selout,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic        busy
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [7:0] WAIT_LAST = 8'(RD_LATENCY - 1);

  tgt_state_t    state_r;
  logic [AW-1:0] addr_r;
  logic [1:0]    len_r;
  logic [3:0]    beat_cnt_r;
  logic [3:0]    rd_cnt_r;
  logic [7:0]    wait_cnt_r;
  logic          rd_q_vld_r;
  logic          ack_r;
  logic          busy_r;
  rsp_t          rsp_r;

  logic [3:0]    beats_s;
  logic          accept_s;
  logic          issue_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_addr_s;
  logic [31:0]   ram_q_s;

  vid_mem_sp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (addrdatain),
    .rdata (ram_q_s)
  );

  // Reads are issued one cycle ahead of each beat so the RAM output register
  // lines up with the response register and bursts stream without bubbles.
  always_comb begin
    beats_s    = len_to_beats(len_r);
    accept_s   = (state_r == ST_IDLE) && (reqin != 2'b00) && (reqtar == TARGET_ID);
    issue_s    = 1'b0;
    ram_we_s   = 1'b0;
    ram_addr_s = addr_r + AW'(rd_cnt_r);
    case (state_r)
      ST_RWAIT: issue_s = (wait_cnt_r == WAIT_LAST);
      ST_RDATA: issue_s = (rd_cnt_r != beats_s);
      ST_WDATA: begin
        ram_we_s   = (cmdin == CMD_WRDATA);
        ram_addr_s = addr_r + AW'(beat_cnt_r);
      end
      default: begin
        issue_s  = 1'b0;
        ram_we_s = 1'b0;
      end
    endcase
  end

  // Burst FSM with registered ack, busy and response channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      len_r      <= 2'b00;
      beat_cnt_r <= 4'd0;
      rd_cnt_r   <= 4'd0;
      wait_cnt_r <= 8'd0;
      rd_q_vld_r <= 1'b0;
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
      rsp_r      <= RSP_IDLE;
    end else begin
      ack_r      <= 1'b0;
      rd_q_vld_r <= issue_s;
      rsp_r      <= RSP_IDLE;
      if (rd_q_vld_r) begin
        rsp_r <= '{sel: 1'b1, cmd: CMD_RDDATA, len: len_r, data: ram_q_s};
      end
      if (issue_s) begin
        rd_cnt_r <= rd_cnt_r + 4'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ack_r      <= 1'b1;
            busy_r     <= 1'b1;
            addr_r     <= addrdatain[AW+1:2];
            len_r      <= lenin;
            beat_cnt_r <= 4'd0;
            rd_cnt_r   <= 4'd0;
            wait_cnt_r <= 8'd0;
            if (cmdin == CMD_READ) begin
              state_r <= ST_RWAIT;
            end else if (cmdin == CMD_WRITE) begin
              state_r <= ST_WDATA;
            end else begin
              state_r <= ST_ERR;
            end
          end
        end
        ST_RWAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r <= ST_RDATA;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_RDATA: begin
          if (rsp_r.sel) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
            if (beat_cnt_r == beats_s - 4'd1) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        ST_WDATA: begin
          if (ram_we_s) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
            if (beat_cnt_r == beats_s - 4'd1) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        ST_ERR: begin
          rsp_r   <= '{sel: 1'b1, cmd: CMD_ERR, len: len_r, data: 32'h0000_0000};
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ackout      = ack_r;
  assign busy        = busy_r;
  assign selout      = rsp_r.sel;
  assign cmdout      = rsp_r.cmd;
  assign lenout      = rsp_r.len;
  assign addrdataout = rsp_r.data;

endmodule

// File: tb/tb_vid_mem_target.sv
// Directed bench for vid_mem_target: write/read bursts, wrong target, write
// stall, address wrap, held request, illegal command and async reset.
module tb_vid_mem_target;
  import vid_bus_pkg::*;

  localparam int DEPTH = 1024;
  localparam int RDL   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  reqin;
  logic [3:0]  reqtar;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackout;
  logic        selout;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [DEPTH];

  vid_mem_target #(.TARGET_ID(TID_MEM), .DEPTH(DEPTH), .RD_LATENCY(RDL)) dut (
    .clk         (clk),
    .reset       (reset),
    .reqin       (reqin),
    .reqtar      (reqtar),
    .cmdin       (cmdin),
    .lenin       (lenin),
    .addrdatain  (addrdatain),
    .ackout      (ackout),
    .selout      (selout),
    .cmdout      (cmdout),
    .lenout      (lenout),
    .addrdataout (addrdataout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    reqin      = 2'b00;
    reqtar     = 4'h0;
    cmdin      = 3'b000;
    lenin      = 2'b00;
    addrdatain = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] baddr, input logic [1:0] len,
                          input logic [31:0] base, input int stall_at);
    int w;
    int n;
    w = int'(baddr[11:2]);
    n = 1 << len;
    reqin = 2'b01; reqtar = TID_MEM; cmdin = 3'b010; lenin = len; addrdatain = baddr;
    step();
    chk("wr_ack", 32'(ackout), 32'd1);
    chk("wr_busy_on", 32'(busy), 32'd1);
    reqin = 2'b00;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        cmdin = 3'b000; addrdatain = 32'hDEAD_BEEF;
        for (int s = 0; s < 2; s++) begin
          step();
          chk("wr_stall_busy", 32'(busy), 32'd1);
        end
      end
      cmdin = 3'b011; addrdatain = base + 32'(i);
      model[(w + i) % DEPTH] = base + 32'(i);
      step();
      chk("wr_no_ack", 32'(ackout), 32'd0);
      chk("wr_busy", 32'(busy), (i == n - 1) ? 32'd0 : 32'd1);
    end
    idle_inputs();
  endtask

  task automatic do_read(input logic [31:0] baddr, input logic [1:0] len);
    int w;
    int n;
    w = int'(baddr[11:2]);
    n = 1 << len;
    reqin = 2'b01; reqtar = TID_MEM; cmdin = 3'b001; lenin = len; addrdatain = baddr;
    step();
    chk("rd_ack", 32'(ackout), 32'd1);
    chk("rd_busy_on", 32'(busy), 32'd1);
    idle_inputs();
    for (int k = 0; k < RDL; k++) begin
      step();
      chk("rd_gap_sel", 32'(selout), 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      step();
      chk("rd_sel", 32'(selout), 32'd1);
      chk("rd_cmd", 32'(cmdout), 32'd4);
      chk("rd_len", 32'(lenout), 32'(len));
      chk("rd_data", addrdataout, model[(w + i) % DEPTH]);
      chk("rd_busy", 32'(busy), 32'd1);
    end
    step();
    chk("rd_end_sel", 32'(selout), 32'd0);
    chk("rd_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    chk("rst_ack", 32'(ackout), 32'd0);
    chk("rst_sel", 32'(selout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'(cmdout), 32'd0);
    chk("rst_len", 32'(lenout), 32'd0);
    chk("rst_data", addrdataout, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // write A0..A3 at byte 0x100, read back
    do_write(32'h0000_0100, 2'd2, 32'h0000_00A0, -1);
    do_read(32'h0000_0100, 2'd2);

    // wrong target and reqin==0 are both ignored
    reqin = 2'b01; reqtar = TID_AUX; cmdin = 3'b001; lenin = 2'd0; addrdatain = 32'h100;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("wrong_tar_ack", 32'(ackout), 32'd0);
      chk("wrong_tar_sel", 32'(selout), 32'd0);
    end
    reqin = 2'b00; reqtar = TID_MEM;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("noreq_ack", 32'(ackout), 32'd0);
    end
    idle_inputs();

    // write with a 2-cycle WRDATA stall, then read back B0..B7
    do_write(32'h0000_0200, 2'd3, 32'h0000_00B0, 3);
    do_read(32'h0000_0200, 2'd3);

    // wrap: 8 beats from word DEPTH-3; low address bits ignored on read
    do_write(32'h0000_0FF4, 2'd3, 32'h0000_00C0, -1);
    do_read(32'h0000_0FF7, 2'd3);
    do_read(32'h0000_0000, 2'd2);
    chk("wrap_model_w0", model[0], 32'h0000_00C3);

    // READ held during a 2-beat read burst
    reqin = 2'b01; reqtar = TID_MEM; cmdin = 3'b001; lenin = 2'd1; addrdatain = 32'h0000_0100;
    step();
    chk("held_first_ack", 32'(ackout), 32'd1);
    lenin = 2'd0; addrdatain = 32'h0000_0108;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("held_no_ack", 32'(ackout), 32'd0);
      if (c == 3) chk("held_beat0", addrdataout, 32'h0000_00A0);
      else if (c == 4) chk("held_beat1", addrdataout, 32'h0000_00A1);
      else chk("held_nosel", 32'(selout), 32'd0);
    end
    step();
    chk("held_second_ack", 32'(ackout), 32'd1);
    chk("held_second_busy", 32'(busy), 32'd1);
    idle_inputs();
    step(); step();
    chk("held2_gap", 32'(selout), 32'd0);
    step();
    chk("held2_sel", 32'(selout), 32'd1);
    chk("held2_data", addrdataout, 32'h0000_00A2);
    step();
    chk("held2_end", 32'(busy), 32'd0);

    // illegal command WRDATA on the request cycle
    reqin = 2'b01; reqtar = TID_MEM; cmdin = 3'b011; lenin = 2'd1; addrdatain = 32'h0000_0100;
    step();
    chk("err_ack", 32'(ackout), 32'd1);
    chk("err_nosel", 32'(selout), 32'd0);
    idle_inputs();
    step();
    chk("err_sel", 32'(selout), 32'd1);
    chk("err_cmd", 32'(cmdout), 32'd7);
    chk("err_data", addrdataout, 32'd0);
    chk("err_ack_off", 32'(ackout), 32'd0);
    step();
    chk("err_done_sel", 32'(selout), 32'd0);
    chk("err_done_cmd", 32'(cmdout), 32'd0);

    // async reset in the middle of an 8-beat read
    reqin = 2'b01; reqtar = TID_MEM; cmdin = 3'b001; lenin = 2'd3; addrdatain = 32'h0000_0200;
    step();
    idle_inputs();
    step(); step(); step();
    chk("mid_beat0", addrdataout, 32'h0000_00B0);
    step();
    chk("mid_beat1", addrdataout, 32'h0000_00B1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(selout), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ackout), 32'd0);
    chk("mid_rst_data", addrdataout, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("after_rst_sel", 32'(selout), 32'd0);
    do_read(32'h0000_0200, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
